// File: rtl/rs_dsp_pkg.sv
// Shared types and width helpers for the rs_dsp multiply-accumulate family.
package rs_dsp_pkg;

  typedef enum logic [2:0] {
    FB_MUL   = 3'd0,
    FB_ADD   = 3'd1,
    FB_SUB   = 3'd2,
    FB_LOAD  = 3'd3,
    FB_CLEAR = 3'd4
  } fb_e;

  typedef enum logic [1:0] {
    OS_ACC  = 2'd0,
    OS_PROD = 2'd1,
    OS_RND  = 2'd2,
    OS_ZERO = 2'd3
  } os_e;

  typedef struct packed {
    logic       ua;
    logic       ub;
    logic [2:0] fb;
    logic [1:0] os;
  } ctl_t;

  // Both operands gain one extension bit before the signed multiply.
  function automatic int prod_width(input int aw, input int bw);
    return aw + bw + 2;
  endfunction

  function automatic bit acc_width_ok(input int aw, input int bw, input int accw);
    return accw >= aw + bw + 1;
  endfunction

  function automatic bit round_cfg_ok(input int accw, input int shift, input int outw);
    return (shift >= 0) && (shift <= accw - 2) && (outw <= accw) && (outw >= 2);
  endfunction

endpackage

// File: rtl/rs_dsp_round_sat.sv
// Arithmetic right shift with round-half-up, then signed saturation to OUT_WIDTH.
module rs_dsp_round_sat #(
  parameter int ACC_WIDTH = 48,
  parameter int SHIFT     = 0,
  parameter int OUT_WIDTH = 38
) (
  input  logic [ACC_WIDTH-1:0] din,
  output logic [ACC_WIDTH-1:0] dout
);

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  localparam int XW = ACC_WIDTH + 1;
  localparam logic signed [XW-1:0] HALF = (XW'(1) << SHIFT) >> 1;
  localparam logic signed [XW-1:0] OMAX = (XW'(1) << (OUT_WIDTH - 1)) - XW'(1);
  localparam logic signed [XW-1:0] OMIN = ~OMAX;

  logic signed [XW-1:0] din_x;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] shf;
  logic signed [XW-1:0] sat;

  assign din_x = {din[ACC_WIDTH-1], din};
  assign rnd   = din_x + HALF;
  assign shf   = rnd >>> SHIFT;

  always_comb begin
    sat = shf;
    if (shf > OMAX) begin
      sat = OMAX;
    end else if (shf < OMIN) begin
      sat = OMIN;
    end
  end

  assign dout = ACC_WIDTH'(sat);

endmodule

// File: rtl/rs_dsp_mac_pipe.sv
// Pipelined signed/unsigned MAC: optional input register, product register, accumulator/output register.
module rs_dsp_mac_pipe
  import rs_dsp_pkg::*;
#(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int IN_REG    = 1,
  parameter int SATURATE  = 1,
  parameter int SHIFT     = 0,
  parameter int OUT_WIDTH = 38
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 unsigned_a,
  input  logic                 unsigned_b,
  input  logic [2:0]           feedback,
  input  logic [1:0]           output_select,
  output logic [ACC_WIDTH-1:0] z,
  output logic                 out_valid,
  output logic                 overflow
);

  localparam int PW = prod_width(A_WIDTH, B_WIDTH);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic               v0;
  logic [A_WIDTH-1:0] a0;
  logic [B_WIDTH-1:0] b0;
  ctl_t               ctl0;

  generate
    if (IN_REG != 0) begin : g_in_reg
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          v0   <= 1'b0;
          a0   <= '0;
          b0   <= '0;
          ctl0 <= '0;
        end else begin
          v0   <= in_valid;
          a0   <= a;
          b0   <= b;
          ctl0 <= {unsigned_a, unsigned_b, feedback, output_select};
        end
      end
    end else begin : g_no_in_reg
      assign v0   = in_valid;
      assign a0   = a;
      assign b0   = b;
      assign ctl0 = {unsigned_a, unsigned_b, feedback, output_select};
    end
  endgenerate

  logic signed [A_WIDTH:0] a_ext;
  logic signed [B_WIDTH:0] b_ext;
  logic signed [PW-1:0]    prod_full;

  assign a_ext     = {~ctl0.ua & a0[A_WIDTH-1], a0};
  assign b_ext     = {~ctl0.ub & b0[B_WIDTH-1], b0};
  assign prod_full = PW'(a_ext) * PW'(b_ext);

  logic                 v1;
  logic [2:0]           fb1;
  logic [1:0]           os1;
  logic [ACC_WIDTH-1:0] p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1  <= 1'b0;
      fb1 <= '0;
      os1 <= '0;
      p1  <= '0;
    end else begin
      v1  <= v0;
      fb1 <= ctl0.fb;
      os1 <= ctl0.os;
      p1  <= ACC_WIDTH'(prod_full);
    end
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum_x;
  logic [ACC_WIDTH-1:0] acc_n;
  logic [ACC_WIDTH-1:0] rnd_out;
  logic [ACC_WIDTH-1:0] z_n;
  logic                 ovf_n;

  // Full-precision sum: overflow shows up as disagreement of the top two bits.
  assign sum_x = (fb1 == FB_SUB) ? ({acc[ACC_WIDTH-1], acc} - {p1[ACC_WIDTH-1], p1})
                                 : ({acc[ACC_WIDTH-1], acc} + {p1[ACC_WIDTH-1], p1});

  always_comb begin
    acc_n = p1;
    ovf_n = overflow;
    case (fb1)
      FB_ADD, FB_SUB: begin
        acc_n = sum_x[ACC_WIDTH-1:0];
        if (sum_x[ACC_WIDTH] != sum_x[ACC_WIDTH-1]) begin
          ovf_n = 1'b1;
          if (SATURATE != 0) begin
            acc_n = sum_x[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
          end
        end
      end
      FB_LOAD: begin
        acc_n = p1;
        ovf_n = 1'b0;
      end
      FB_CLEAR: begin
        acc_n = '0;
        ovf_n = 1'b0;
      end
      default: acc_n = p1;
    endcase
  end

  rs_dsp_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .din  (acc_n),
    .dout (rnd_out)
  );

  always_comb begin
    z_n = '0;
    case (os1)
      OS_ACC:  z_n = acc_n;
      OS_PROD: z_n = p1;
      OS_RND:  z_n = rnd_out;
      default: z_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      overflow  <= 1'b0;
      z         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        acc      <= acc_n;
        overflow <= ovf_n;
        z        <= z_n;
      end
    end
  end

endmodule

// File: tb/tb_rs_dsp_mac_pipe.sv
// Bench for rs_dsp_mac_pipe: default build plus 40-bit saturating and wrapping builds on shared inputs.
module tb_rs_dsp_mac_pipe;
  import rs_dsp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [19:0] a = '0;
  logic [17:0] b = '0;
  logic        unsigned_a = 1'b0;
  logic        unsigned_b = 1'b0;
  logic [2:0]  feedback = '0;
  logic [1:0]  output_select = '0;

  logic [47:0] z_d;
  logic [39:0] z_s, z_w;
  logic        v_d, v_s, v_w;
  logic        ov_d, ov_s, ov_w;

  always #5 clk = ~clk;

  rs_dsp_mac_pipe dut_d (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .unsigned_a(unsigned_a), .unsigned_b(unsigned_b), .feedback(feedback),
    .output_select(output_select), .z(z_d), .out_valid(v_d), .overflow(ov_d)
  );

  rs_dsp_mac_pipe #(.ACC_WIDTH(40), .SATURATE(1), .SHIFT(4), .OUT_WIDTH(16)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .unsigned_a(unsigned_a), .unsigned_b(unsigned_b), .feedback(feedback),
    .output_select(output_select), .z(z_s), .out_valid(v_s), .overflow(ov_s)
  );

  rs_dsp_mac_pipe #(.ACC_WIDTH(40), .SATURATE(0), .SHIFT(4), .OUT_WIDTH(16)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .unsigned_a(unsigned_a), .unsigned_b(unsigned_b), .feedback(feedback),
    .output_select(output_select), .z(z_w), .out_valid(v_w), .overflow(ov_w)
  );

  typedef struct packed {
    logic [19:0] a;
    logic [17:0] b;
    logic        ua;
    logic        ub;
    logic [2:0]  fb;
    logic [1:0]  os;
  } beat_t;

  // cdut: -1 no constant check, 0 default build, 1 saturating 40-bit build
  typedef struct {
    beat_t       bt;
    int          bub;
    int          cdut;
    logic [47:0] cz;
    bit          covf;
  } vec_t;

  typedef struct {
    int          due;
    logic [47:0] zd;
    logic [39:0] zs;
    logic [39:0] zw;
    bit          od;
    bit          osat;
    bit          ow;
    int          cdut;
    logic [47:0] cz;
    bit          covf;
  } exp_t;

  exp_t   q[$];
  vec_t   vt[13];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  longint acc_d = 0, acc_s = 0, acc_w = 0;
  bit     m_od = 0, m_os = 0, m_ow = 0;
  logic [47:0] last_zd = '0;
  logic [39:0] last_zs = '0, last_zw = '0;
  bit     last_od = 0, last_os = 0, last_ow = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: integer arithmetic straight from the accumulate/overflow/rounding rules.
  function automatic void mdl(input int w, input bit sat, input int sh, input int ow,
                              input beat_t bt, inout longint acc, inout bit ovf,
                              output longint zo);
    longint av, bv, p, s, hi, lo, m, r, ohi;
    av  = bt.ua ? longint'(bt.a) : longint'($signed(bt.a));
    bv  = bt.ub ? longint'(bt.b) : longint'($signed(bt.b));
    p   = av * bv;
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -hi - 1;
    case (bt.fb)
      3'd1, 3'd2: begin
        s = (bt.fb == 3'd1) ? acc + p : acc - p;
        if (s > hi || s < lo) begin
          ovf = 1'b1;
          if (sat) begin
            acc = (s > hi) ? hi : lo;
          end else begin
            m   = longint'(1) << w;
            r   = s & (m - 1);
            acc = (r > hi) ? r - m : r;
          end
        end else begin
          acc = s;
        end
      end
      3'd3: begin acc = p; ovf = 1'b0; end
      3'd4: begin acc = 0; ovf = 1'b0; end
      default: acc = p;
    endcase
    case (bt.os)
      2'd0: zo = acc;
      2'd1: zo = p;
      2'd2: begin
        r   = (acc + ((longint'(1) << sh) >> 1)) >>> sh;
        ohi = (longint'(1) << (ow - 1)) - 1;
        zo  = (r > ohi) ? ohi : ((r < -ohi - 1) ? -ohi - 1 : r);
      end
      default: zo = 0;
    endcase
  endfunction

  function automatic beat_t mk(input logic [19:0] aa, input logic [17:0] bb, input logic u1,
                               input logic u2, input logic [2:0] f, input logic [1:0] o);
    return {aa, bb, u1, u2, f, o};
  endfunction

  function automatic vec_t mkv(input beat_t bt, input int bub, input int cdut,
                               input logic [47:0] cz, input bit covf);
    vec_t v;
    v.bt = bt; v.bub = bub; v.cdut = cdut; v.cz = cz; v.covf = covf;
    return v;
  endfunction

  function automatic beat_t rnd_beat();
    return mk(20'($urandom), 18'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_valid", 64'({v_d, v_s, v_w}), 64'(3'b111));
      chk("z_default", 64'(z_d), 64'(e.zd));
      chk("z_sat40", 64'(z_s), 64'(e.zs));
      chk("z_wrap40", 64'(z_w), 64'(e.zw));
      chk("overflow", 64'({ov_d, ov_s, ov_w}), 64'({e.od, e.osat, e.ow}));
      if (e.cdut == 0) begin
        chk("const_z_default", 64'(z_d), 64'(e.cz));
        chk("const_ovf_default", 64'(ov_d), 64'(e.covf));
      end else if (e.cdut == 1) begin
        chk("const_z_sat40", 64'(z_s), 64'(e.cz[39:0]));
        chk("const_ovf_sat40", 64'(ov_s), 64'(e.covf));
      end
      last_zd = e.zd; last_zs = e.zs; last_zw = e.zw;
      last_od = e.od; last_os = e.osat; last_ow = e.ow;
    end else begin
      chk("idle_out_valid", 64'({v_d, v_s, v_w}), 64'(0));
      chk("idle_z_hold_d", 64'(z_d), 64'(last_zd));
      chk("idle_z_hold_s", 64'(z_s), 64'(last_zs));
      chk("idle_z_hold_w", 64'(z_w), 64'(last_zw));
      chk("idle_ovf_hold", 64'({ov_d, ov_s, ov_w}), 64'({last_od, last_os, last_ow}));
    end
  endtask

  task automatic drive(input beat_t bt, input logic v);
    a = bt.a; b = bt.b; unsigned_a = bt.ua; unsigned_b = bt.ub;
    feedback = bt.fb; output_select = bt.os; in_valid = v;
  endtask

  task automatic issue(input beat_t bt, input int cdut, input logic [47:0] cz, input bit covf);
    exp_t   e;
    longint zz;
    drive(bt, 1'b1);
    mdl(48, 1'b1, 0, 38, bt, acc_d, m_od, zz); e.zd = 48'(zz); e.od = m_od;
    mdl(40, 1'b1, 4, 16, bt, acc_s, m_os, zz); e.zs = 40'(zz); e.osat = m_os;
    mdl(40, 1'b0, 4, 16, bt, acc_w, m_ow, zz); e.zw = 40'(zz); e.ow = m_ow;
    e.due = cyc + 3; e.cdut = cdut; e.cz = cz; e.covf = covf;
    q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic bubble();
    drive(rnd_beat(), 1'b0);
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 6 && q.size() > 0; k++) bubble();
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic clear_model();
    q.delete();
    acc_d = 0; acc_s = 0; acc_w = 0;
    m_od = 0; m_os = 0; m_ow = 0;
    last_zd = '0; last_zs = '0; last_zw = '0;
    last_od = 0; last_os = 0; last_ow = 0;
  endtask

  task automatic check_reset_now(input string nm);
    chk({nm, "_z_d"}, 64'(z_d), 64'(0));
    chk({nm, "_z_s"}, 64'(z_s), 64'(0));
    chk({nm, "_z_w"}, 64'(z_w), 64'(0));
    chk({nm, "_flags"}, 64'({v_d, v_s, v_w, ov_d, ov_s, ov_w}), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mkv(mk(20'd3, 18'h3FFFB, 0, 0, 3'd0, 2'd0), 1, 0, 48'hFFFF_FFFF_FFF1, 0);
    vt[1]  = mkv(mk(20'd100, 18'd2, 0, 0, 3'd3, 2'd0), 0, 0, 48'd200, 0);
    vt[2]  = mkv(mk(20'd7, 18'd3, 0, 0, 3'd1, 2'd0), 2, 0, 48'd221, 0);
    vt[3]  = mkv(mk(20'd7, 18'd3, 0, 0, 3'd1, 2'd0), 0, 0, 48'd242, 0);
    vt[4]  = mkv(mk(20'd1, 18'd1, 0, 0, 3'd2, 2'd0), 0, 0, 48'd241, 0);
    vt[5]  = mkv(mk(20'hFFFFF, 18'h3FFFF, 1, 1, 3'd0, 2'd0), 0, 0, 48'h003F_FFEC_0001, 0);
    vt[6]  = mkv(mk(20'hFFFFF, 18'h3FFFF, 0, 0, 3'd0, 2'd0), 0, 0, 48'd1, 0);
    vt[7]  = mkv(mk(20'd2, 18'd3, 0, 0, 3'd1, 2'd1), 0, 0, 48'd6, 0);
    vt[8]  = mkv(mk(20'd9, 18'd9, 0, 0, 3'd0, 2'd3), 0, 0, 48'd0, 0);
    vt[9]  = mkv(mk(20'd5, 18'd5, 0, 0, 3'd7, 2'd0), 0, 0, 48'd25, 0);
    vt[10] = mkv(mk(20'd24, 18'd1, 0, 0, 3'd3, 2'd2), 0, 1, 48'd2, 0);
    vt[11] = mkv(mk(20'hFFFE8, 18'd1, 0, 0, 3'd3, 2'd2), 0, 1, 48'h00FF_FFFF_FFFF, 0);
    vt[12] = mkv(mk(20'h7FFFF, 18'd16, 0, 0, 3'd3, 2'd2), 0, 1, 48'h7FFF, 0);

    // Reset held with live random inputs.
    #1 reset = 1'b0;
    drive(rnd_beat(), 1'b1);
    #1 check_reset_now("reset_hold");
    for (int k = 0; k < 4; k++) begin
      drive(rnd_beat(), 1'b1);
      step();
    end
    #2 reset = 1'b1;
    in_valid = 1'b0;
    bubble();
    bubble();

    for (int i = 0; i < 13; i++) begin
      issue(vt[i].bt, vt[i].cdut, vt[i].cz, vt[i].covf);
      for (int k = 0; k < vt[i].bub; k++) bubble();
    end
    drain();

    // Saturate/wrap at 40 bits, then rounded output must leave overflow alone.
    issue(mk(20'h7FFFF, 18'h1FFFF, 0, 0, 3'd3, 2'd0), -1, '0, 0);
    for (int k = 0; k < 9; k++) issue(mk(20'h7FFFF, 18'h1FFFF, 0, 0, 3'd1, 2'd0), -1, '0, 0);
    drain();
    chk("sat40_clamp", 64'(z_s), 64'(40'h7F_FFFF_FFFF));
    chk("sat40_ovf", 64'(ov_s), 64'(1));
    chk("wrap40_ovf", 64'(ov_w), 64'(1));
    chk("wrap40_negative", 64'(z_w[39]), 64'(1));
    issue(mk(20'h7FFFF, 18'd16, 0, 0, 3'd0, 2'd2), 1, 48'h7FFF, 1);
    issue(mk(20'h12345, 18'h1234, 0, 0, 3'd4, 2'd0), 1, 48'd0, 0);
    drain();
    chk("clear_ovf_wrap40", 64'(ov_w), 64'(0));
    chk("clear_z_wrap40", 64'(z_w), 64'(0));

    // Reset in the middle of in-flight beats.
    issue(mk(20'd11, 18'd13, 0, 0, 3'd3, 2'd0), -1, '0, 0);
    issue(mk(20'd17, 18'd19, 0, 0, 3'd1, 2'd0), -1, '0, 0);
    #2 reset = 1'b0;
    #1 check_reset_now("reset_mid");
    clear_model();
    for (int k = 0; k < 3; k++) begin
      drive(rnd_beat(), 1'b1);
      step();
    end
    #2 reset = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) bubble();
    issue(mk(20'd2, 18'd2, 0, 0, 3'd0, 2'd0), 0, 48'd4, 0);
    drain();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bubble();
      else issue(rnd_beat(), -1, '0, 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
